// File: rtl/imem_ctrl_pkg.sv
// Shared encodings for the instruction-RAM fetch/load controller:
// FSM states, fetch alignment codes and arbiter grant identifiers.
package imem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_LO = 2'd1,
    RD_HI = 2'd2
  } state_t;

  localparam logic [1:0] ALIGN_W = 2'b00;
  localparam logic [1:0] ALIGN_H = 2'b10;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_LOAD  = 1'b1
  } gnt_t;

endpackage

// File: rtl/imem_fetch_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; grants only while i_slot_en is high, zero latency.
// A losing requester simply sees no grant and keeps requesting; the last winner loses ties.
module rr_arb2
  import imem_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_slot_en,
  input  logic i_fetch_req,
  input  logic i_load_req,
  output logic o_gnt_fetch,
  output logic o_gnt_load
);

  gnt_t r_last;

  always_comb begin
    o_gnt_fetch = 1'b0;
    o_gnt_load  = 1'b0;
    if (i_slot_en) begin
      if (i_fetch_req && i_load_req) begin
        if (r_last == GNT_FETCH) o_gnt_load  = 1'b1;
        else                     o_gnt_fetch = 1'b1;
      end else begin
        o_gnt_fetch = i_fetch_req;
        o_gnt_load  = i_load_req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= GNT_FETCH;
    end else if (o_gnt_load) begin
      r_last <= GNT_LOAD;
    end else if (o_gnt_fetch) begin
      r_last <= GNT_FETCH;
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Shares a sync-read instruction RAM between fetch and program load; fetch latency 1 (word) or 2 (halfword).
// Requests wait without being dropped: grants only happen in IDLE or in the cycle a fetch completes.
module imem_fetch_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter  int ADDRESS_SIZE = 10,
  parameter  int N            = 32,
  localparam int WORD_AW      = ADDRESS_SIZE - 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fetch_req,
  input  logic [ADDRESS_SIZE-1:0] fetch_addr,
  output logic                    fetch_ready,
  output logic                    instr_valid,
  output logic [N-1:0]            instruction,
  output logic                    fetch_err,
  input  logic                    load_req,
  input  logic [WORD_AW-1:0]      load_addr,
  input  logic [N-1:0]            load_data,
  output logic                    load_ack,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [WORD_AW-1:0]      mem_addr,
  output logic [N-1:0]            mem_wdata,
  input  logic [N-1:0]            mem_rdata
);

  state_t             r_state, w_state_nxt;
  logic [1:0]         r_align, w_align_nxt;
  logic [WORD_AW-1:0] r_word,  w_word_nxt;
  logic [N/2-1:0]     r_hold,  w_hold_nxt;
  logic               r_err,   w_err_nxt;

  logic w_done;
  logic w_slot;
  logic w_gnt_fetch;
  logic w_gnt_load;

  // A fetch completes in RD_LO for word-aligned addresses, otherwise in RD_HI.
  assign w_done = ((r_state == RD_LO) && (r_align == ALIGN_W)) || (r_state == RD_HI);
  assign w_slot = rst && ((r_state == IDLE) || w_done);

  rr_arb2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .i_slot_en   (w_slot),
    .i_fetch_req (fetch_req),
    .i_load_req  (load_req),
    .o_gnt_fetch (w_gnt_fetch),
    .o_gnt_load  (w_gnt_load)
  );

  assign fetch_ready = w_gnt_fetch;
  assign load_ack    = w_gnt_load;
  assign fetch_err   = r_err;
  assign instr_valid = w_done;

  always_comb begin
    instruction = '0;
    if (w_done) begin
      if (r_align == ALIGN_W) instruction = mem_rdata;
      else                    instruction = {mem_rdata[N/2-1:0], r_hold};
    end
  end

  always_comb begin
    w_state_nxt = IDLE;
    w_align_nxt = r_align;
    w_word_nxt  = r_word;
    w_hold_nxt  = r_hold;
    w_err_nxt   = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;

    // Second read of a straddling fetch; the next word index wraps naturally.
    if ((r_state == RD_LO) && (r_align == ALIGN_H)) begin
      w_hold_nxt  = mem_rdata[N-1:N/2];
      mem_en      = 1'b1;
      mem_addr    = r_word + WORD_AW'(1);
      w_state_nxt = RD_HI;
    end

    if (w_gnt_load) begin
      mem_en      = 1'b1;
      mem_we      = 1'b1;
      mem_addr    = load_addr;
      mem_wdata   = load_data;
      w_state_nxt = IDLE;
    end else if (w_gnt_fetch) begin
      if (fetch_addr[0]) begin
        w_err_nxt   = 1'b1;
        w_state_nxt = IDLE;
      end else begin
        mem_en      = 1'b1;
        mem_addr    = fetch_addr[ADDRESS_SIZE-1:2];
        w_align_nxt = fetch_addr[1:0];
        w_word_nxt  = fetch_addr[ADDRESS_SIZE-1:2];
        w_state_nxt = RD_LO;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_align <= ALIGN_W;
      r_word  <= '0;
      r_hold  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_align <= w_align_nxt;
      r_word  <= w_word_nxt;
      r_hold  <= w_hold_nxt;
      r_err   <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: RAM model, directed scenarios, then randomized fetch/load traffic
// scored against a word-array reference model through an expectation queue.
module tb_imem_fetch_ctrl;

  localparam int AS  = 10;
  localparam int DW  = 32;
  localparam int WAW = AS - 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           fetch_req = 1'b0;
  logic [AS-1:0]  fetch_addr = '0;
  logic           fetch_ready;
  logic           instr_valid;
  logic [DW-1:0]  instruction;
  logic           fetch_err;
  logic           load_req = 1'b0;
  logic [WAW-1:0] load_addr = '0;
  logic [DW-1:0]  load_data = '0;
  logic           load_ack;
  logic           mem_en;
  logic           mem_we;
  logic [WAW-1:0] mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic [DW-1:0]  mem_rdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic        err;
    logic [31:0] ins;
    int          t;
    int          lat;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model [256];
  logic [31:0] ram   [256];

  always #5 clk = ~clk;

  imem_fetch_ctrl #(.ADDRESS_SIZE(AS), .N(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .instr_valid (instr_valid),
    .instruction (instruction),
    .fetch_err   (fetch_err),
    .load_req    (load_req),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_ack    (load_ack),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  // Single-port synchronous-read RAM macro model.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t predict(input logic [AS-1:0] a, input int now);
    exp_t e;
    int   w;
    w     = int'(a) / 4;
    e.t   = now;
    e.err = 1'b0;
    e.ins = 32'h0;
    e.lat = 1;
    if (int'(a) % 2 == 1) begin
      e.err = 1'b1;
    end else if (int'(a) % 4 == 0) begin
      e.ins = model[w];
    end else begin
      e.ins = {model[(w + 1) % 256][15:0], model[w][31:16]};
      e.lat = 2;
    end
    return e;
  endfunction

  // Scoreboard: retire responses, check idle/reset invariants, then record new acceptances.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst) begin
      q.delete();
      chk("rst_ctl_zero", 32'({fetch_ready, instr_valid, fetch_err, load_ack, mem_en, mem_we, mem_addr}), 32'h0);
      chk("rst_dat_zero", instruction | mem_wdata, 32'h0);
    end else begin
      if (instr_valid || fetch_err) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", 32'({instr_valid, fetch_err}), 32'h0);
        end else begin
          e = q.pop_front();
          chk("rsp_err", 32'(fetch_err), 32'(e.err));
          chk("rsp_valid", 32'(instr_valid), 32'(!e.err));
          chk("rsp_instr", instruction, e.ins);
          chk("rsp_latency", 32'(cyc - e.t), 32'(e.lat));
        end
      end else if (q.size() > 0 && (cyc - q[0].t) > 2) begin
        e = q.pop_front();
        chk("rsp_timeout_age", 32'(cyc - e.t), 32'(e.lat));
      end
      if (!instr_valid) chk("instr_zero_idle", instruction, 32'h0);
      if (!mem_en) chk("mem_idle_zero", 32'({mem_we, mem_addr}) | mem_wdata, 32'h0);
      if (fetch_ready && load_ack) chk("single_grant", 32'({fetch_ready, load_ack}), 32'h0);
      if (fetch_req && fetch_ready) q.push_back(predict(fetch_addr, cyc));
      if (load_req && load_ack) begin
        chk("load_we", 32'({mem_en, mem_we}), 32'h3);
        chk("load_addr", 32'(mem_addr), 32'(load_addr));
        chk("load_wdata", mem_wdata, load_data);
        model[load_addr] = load_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [WAW-1:0] a, input logic [31:0] d);
    logic got;
    got       = 1'b0;
    load_req  = 1'b1;
    load_addr = a;
    load_data = d;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = load_ack;
    end
    chk("load_handshake", 32'(got), 32'h1);
    tick();
    load_req = 1'b0;
  endtask

  task automatic do_fetch(input logic [AS-1:0] a, output logic en, output logic [WAW-1:0] ma);
    logic got;
    got        = 1'b0;
    en         = 1'b0;
    ma         = '0;
    fetch_req  = 1'b1;
    fetch_addr = a;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = fetch_ready;
      en  = mem_en;
      ma  = mem_addr;
    end
    chk("fetch_handshake", 32'(got), 32'h1);
    tick();
    fetch_req = 1'b0;
  endtask

  function automatic logic [AS-1:0] rand_addr();
    int            r;
    logic [AS-1:0] a;
    r = $urandom_range(0, 99);
    a = AS'($urandom_range(0, 255)) << 2;
    if (r < 5)       a = 10'h3FE;
    else if (r < 45) a = a | 10'd2;
    else if (r < 60) a = a | (($urandom_range(0, 1) == 1) ? 10'd1 : 10'd3);
    return a;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic           en;
    logic [WAW-1:0] ma;
    logic           f_acc, l_acc;

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // 1: load then aligned fetch
    do_load(8'd0, 32'h0011_0193);
    do_fetch(10'h000, en, ma);
    @(negedge clk);
    chk("t1_valid", 32'(instr_valid), 32'h1);
    chk("t1_instr", instruction, 32'h0011_0193);
    tick();

    // 2: straddling fetch across words 4/5
    do_load(8'd4, 32'hAAAA_1111);
    do_load(8'd5, 32'h3333_BBBB);
    do_fetch(10'h012, en, ma);
    chk("t2_first_addr", 32'(ma), 32'd4);
    @(negedge clk);
    chk("t2_second_addr", 32'({mem_en, mem_we, mem_addr}), 32'({1'b1, 1'b0, 8'd5}));
    chk("t2_no_early_valid", 32'(instr_valid), 32'h0);
    tick();
    @(negedge clk);
    chk("t2_instr", instruction, 32'hBBBB_AAAA);
    tick();

    // 3: back-to-back aligned fetches
    do_load(8'd1, 32'h1111_2222);
    do_load(8'd2, 32'h3333_4444);
    fetch_req  = 1'b1;
    fetch_addr = 10'h000;
    @(negedge clk);
    chk("t3_ready0", 32'(fetch_ready), 32'h1);
    tick();
    fetch_addr = 10'h004;
    @(negedge clk);
    chk("t3_ready1", 32'(fetch_ready), 32'h1);
    chk("t3_instr0", 32'(instr_valid) ^ instruction, 32'h1 ^ 32'h0011_0193);
    tick();
    fetch_addr = 10'h008;
    @(negedge clk);
    chk("t3_ready2", 32'(fetch_ready), 32'h1);
    chk("t3_instr1", 32'(instr_valid) ^ instruction, 32'h1 ^ 32'h1111_2222);
    tick();
    fetch_req = 1'b0;
    @(negedge clk);
    chk("t3_instr2", 32'(instr_valid) ^ instruction, 32'h1 ^ 32'h3333_4444);
    tick();

    // 4: both requesters from reset alternate, load first
    rst        = 1'b0;
    load_req   = 1'b1;
    load_addr  = 8'd10;
    load_data  = 32'h5A5A_0F0F;
    fetch_req  = 1'b1;
    fetch_addr = 10'h000;
    tick();
    tick();
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t4_grant", 32'({load_ack, fetch_ready}), (k % 2 == 0) ? 32'h2 : 32'h1);
    end
    tick();
    load_req  = 1'b0;
    fetch_req = 1'b0;
    repeat (3) tick();

    // 5: halfword fetch at the top of memory wraps to word 0
    do_load(8'd255, 32'h1234_5678);
    do_load(8'd0, 32'h9ABC_DEF0);
    do_fetch(10'h3FE, en, ma);
    chk("t5_first_addr", 32'(ma), 32'd255);
    @(negedge clk);
    chk("t5_wrap_addr", 32'({mem_en, mem_addr}), 32'({1'b1, 8'd0}));
    tick();
    @(negedge clk);
    chk("t5_instr", instruction, 32'hDEF0_1234);
    tick();

    // 6: odd address error, then reset during the second read
    do_fetch(10'h005, en, ma);
    chk("t6_no_ram", 32'(en), 32'h0);
    @(negedge clk);
    chk("t6_err", 32'({fetch_err, instr_valid}), 32'h2);
    chk("t6_instr_zero", instruction, 32'h0);
    tick();
    do_fetch(10'h012, en, ma);
    tick();
    rst = 1'b0;
    #1;
    chk("t6_rst_ctl", 32'({fetch_ready, instr_valid, fetch_err, load_ack, mem_en, mem_we, mem_addr}), 32'h0);
    chk("t6_rst_dat", instruction | mem_wdata, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    do_fetch(10'h000, en, ma);
    @(negedge clk);
    chk("t6_recover", 32'(instr_valid) ^ instruction, 32'h1 ^ 32'h9ABC_DEF0);
    tick();

    // Randomized traffic over a fully initialised memory
    for (int w = 0; w < 256; w++) do_load(WAW'(w), $urandom);
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      f_acc = fetch_req && fetch_ready;
      l_acc = load_req && load_ack;
      tick();
      if (!fetch_req || f_acc) begin
        fetch_req  = ($urandom_range(0, 9) < 6);
        fetch_addr = rand_addr();
      end
      if (!load_req || l_acc) begin
        load_req  = ($urandom_range(0, 9) < 3);
        load_addr = WAW'($urandom_range(0, 255));
        load_data = $urandom;
      end
    end
    @(negedge clk);
    tick();
    fetch_req = 1'b0;
    load_req  = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    chk("drain_empty", 32'(q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
